exe_stage: RTL and testbench

- Execute stage that sits directly downstream of the ID/EXE pipeline register.
- Consumes that register's operand, immediate and control outputs, and performs the ALU operation and branch resolution.
- Includes an iterative shift-add multiplier that stalls the front of the pipe while it runs.
- Registers all results into an EXE/MEM boundary that feeds the memory stage.

---
 rtl/exe_pkg.sv | 14 +
 rtl/iter_mul.sv | 49 ++++
 rtl/exe_stage.sv | 84 ++++++++
 tb/tb_exe_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: shared widths, ALU opcodes and multiplier FSM states for the execute stage
package exe_pkg;
  localparam int DSIZE = 16;
  localparam int ASIZE = 4;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] MUL_OP  = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mul_state_t;
endpackage

// File: rtl/iter_mul.sv
// iter_mul: iterative shift-add multiplier returning the low DSIZE bits of a*b
module iter_mul #(
  parameter int DSIZE = exe_pkg::DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] product
);
  import exe_pkg::*;
  localparam int CW = $clog2(DSIZE);
  mul_state_t       r_state, w_next;
  logic [DSIZE-1:0] r_acc, r_mcand, r_mplier, w_addend;
  logic [CW-1:0]    r_cnt;
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_next = (r_state == IDLE && start) ? BUSY :
                  (r_state == BUSY && r_cnt == CW'(DSIZE-2)) ? DONE :
                  (r_state == DONE) ? IDLE : r_state;
  assign busy = r_state == BUSY;
  assign done = r_state == DONE;
  // the final partial product is folded in combinationally during DONE
  assign product = r_acc + w_addend;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_acc    <= '0;
        r_mcand  <= a;
        r_mplier <= b;
        r_cnt    <= '0;
      end else if (r_state == BUSY) begin
        r_acc    <= r_acc + w_addend;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/exe_stage.sv
// exe_stage: ALU, branch resolution and EXE/MEM register, stalling upstream during multiply
module exe_stage #(
  parameter int         DSIZE  = exe_pkg::DSIZE,
  parameter int         ASIZE  = exe_pkg::ASIZE,
  parameter logic [2:0] MUL_OP = exe_pkg::MUL_OP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [DSIZE-1:0] imm_in,
  input  logic [2:0]       ALUop_in,
  input  logic             ALUSrc_in,
  input  logic             branch_in,
  input  logic             memWrite_in,
  input  logic             writeEn_in,
  input  logic             jal_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [DSIZE-1:0] nPC_in,
  input  logic             memToReg_in,
  output logic             stall_out,
  output logic [DSIZE-1:0] alu_result_out,
  output logic [DSIZE-1:0] wdata_out,
  output logic             memWrite_out,
  output logic             writeEn_out,
  output logic             jal_out,
  output logic             memToReg_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic [DSIZE-1:0] nPC_out,
  output logic             branch_taken_out,
  output logic [DSIZE-1:0] branch_target_out
);
  import exe_pkg::*;
  logic [DSIZE-1:0] w_b, w_alu, w_product;
  logic             w_is_mul, w_busy, w_done, w_stall;
  assign w_b      = ALUSrc_in ? imm_in : rdata2_in;
  assign w_is_mul = ALUop_in == MUL_OP;
  iter_mul #(.DSIZE(DSIZE)) u_mul (
    .clk(clk), .rst(rst), .start(w_is_mul), .a(rdata1_in), .b(w_b),
    .busy(w_busy), .done(w_done), .product(w_product)
  );
  assign w_stall   = rst & ((w_is_mul & ~w_busy & ~w_done) | w_busy);
  assign stall_out = w_stall;
  always_comb begin
    w_alu = '0;
    case (ALUop_in)
      ALU_ADD: w_alu = rdata1_in + w_b;
      ALU_SUB: w_alu = rdata1_in - w_b;
      ALU_AND: w_alu = rdata1_in & w_b;
      ALU_OR:  w_alu = rdata1_in | w_b;
      ALU_SLL: w_alu = rdata1_in << w_b[3:0];
      ALU_SRL: w_alu = rdata1_in >> w_b[3:0];
      MUL_OP:  w_alu = w_product;
      ALU_SLT: w_alu = {{(DSIZE-1){1'b0}}, $signed(rdata1_in) < $signed(w_b)};
      default: w_alu = '0;
    endcase
  end
  // stalled cycles push a bubble downstream; only the DONE cycle emits the multiply
  always_ff @(posedge clk) begin
    if (!rst || w_stall) begin
      alu_result_out    <= '0;
      wdata_out         <= '0;
      memWrite_out      <= 1'b0;
      writeEn_out       <= 1'b0;
      jal_out           <= 1'b0;
      memToReg_out      <= 1'b0;
      waddr_out         <= '0;
      nPC_out           <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else begin
      alu_result_out    <= w_alu;
      wdata_out         <= rdata2_in;
      memWrite_out      <= memWrite_in;
      writeEn_out       <= writeEn_in;
      jal_out           <= jal_in;
      memToReg_out      <= memToReg_in;
      waddr_out         <= waddr_in;
      nPC_out           <= nPC_in;
      branch_taken_out  <= branch_in & (rdata1_in == rdata2_in);
      branch_target_out <= nPC_in + imm_in;
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: randomized and directed self-checking bench for exe_stage
module tb_exe_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rdata1_in, rdata2_in, imm_in, nPC_in;
  logic [2:0]  ALUop_in;
  logic        ALUSrc_in, branch_in, memWrite_in, writeEn_in, jal_in, memToReg_in;
  logic [3:0]  waddr_in;
  logic        stall_out;
  logic [15:0] alu_result_out, wdata_out, nPC_out, branch_target_out;
  logic        memWrite_out, writeEn_out, jal_out, memToReg_out, branch_taken_out;
  logic [3:0]  waddr_out;
  logic [72:0] act;
  int          checks = 0, errors = 0, cyc = 0;

  exe_stage dut (
    .clk(clk), .rst(rst), .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .ALUop_in(ALUop_in), .ALUSrc_in(ALUSrc_in), .branch_in(branch_in), .memWrite_in(memWrite_in),
    .writeEn_in(writeEn_in), .jal_in(jal_in), .waddr_in(waddr_in), .nPC_in(nPC_in),
    .memToReg_in(memToReg_in), .stall_out(stall_out), .alu_result_out(alu_result_out),
    .wdata_out(wdata_out), .memWrite_out(memWrite_out), .writeEn_out(writeEn_out),
    .jal_out(jal_out), .memToReg_out(memToReg_out), .waddr_out(waddr_out), .nPC_out(nPC_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign act = {alu_result_out, wdata_out, memWrite_out, writeEn_out, jal_out, memToReg_out,
                waddr_out, nPC_out, branch_taken_out, branch_target_out};

  function automatic logic [72:0] model_out();
    logic [15:0] b, r;
    int sh;
    b  = ALUSrc_in ? imm_in : rdata2_in;
    sh = int'(b) % 16;
    case (ALUop_in)
      3'd0:    r = rdata1_in + b;
      3'd1:    r = rdata1_in - b;
      3'd2:    r = rdata1_in & b;
      3'd3:    r = rdata1_in | b;
      3'd4:    r = 16'(int'(rdata1_in) * (2 ** sh));
      3'd5:    r = 16'(int'(rdata1_in) / (2 ** sh));
      3'd6:    r = 16'(int'(rdata1_in) * int'(b));
      default: r = ($signed(rdata1_in) < $signed(b)) ? 16'd1 : 16'd0;
    endcase
    return {r, rdata2_in, memWrite_in, writeEn_in, jal_in, memToReg_in, waddr_in, nPC_in,
            branch_in && (rdata1_in == rdata2_in), 16'(nPC_in + imm_in)};
  endfunction

  task automatic set_in(input logic [2:0] op, input logic [15:0] a, b2, im,
                        input logic src, br, mw, we, jl, m2r,
                        input logic [3:0] wa, input logic [15:0] np);
    ALUop_in = op; rdata1_in = a; rdata2_in = b2; imm_in = im; ALUSrc_in = src;
    branch_in = br; memWrite_in = mw; writeEn_in = we; jal_in = jl; memToReg_in = m2r;
    waddr_in = wa; nPC_in = np;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(3'b110, 16'h1111, 16'h2222, 16'h0003, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 16'h0042);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_out); end
    step();
    checks++; if (act !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", act); end
    set_in(3'b000, 16'h0005, 16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 16'h0011);
    rst = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL release_stall: got %b want 0", stall_out); end
    step();
    checks++; if (act !== model_out()) begin errors++; $display("FAIL release_first_op: got %h want %h", act, model_out()); end
  endtask

  task automatic test_alu_directed();
    logic [2:0]  ops [5] = '{3'd0, 3'd1, 3'd7, 3'd4, 3'd5};
    logic [15:0] as  [5] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h0003, 16'h8000};
    logic [15:0] bs  [5] = '{16'h0001, 16'h0001, 16'h0001, 16'hAAAA, 16'h5555};
    logic [15:0] ims [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0004, 16'h000F};
    logic [15:0] exp [5] = '{16'h8000, 16'hFFFF, 16'h0001, 16'h0030, 16'h0001};
    for (int i = 0; i < 5; i++) begin
      set_in(ops[i], as[i], bs[i], ims[i], i >= 3, 1'b0, 1'b0, i == 3, 1'b0, 1'b0,
             (i == 3) ? 4'd5 : 4'(i), 16'(16'h0100 + i));
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall[%0d]: got %b want 0", i, stall_out); end
      step();
      checks++; if (alu_result_out !== exp[i]) begin errors++; $display("FAIL alu_dir[%0d]: got %h want %h", i, alu_result_out, exp[i]); end
      checks++; if (act !== model_out()) begin errors++; $display("FAIL alu_dir_all[%0d]: got %h want %h", i, act, model_out()); end
      if (i == 3) begin
        checks++; if ({writeEn_out, waddr_out} !== {1'b1, 4'd5}) begin errors++; $display("FAIL alu_wb_fields: got %b/%0d want 1/5", writeEn_out, waddr_out); end
      end
    end
  endtask

  task automatic test_alu_random();
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6) op = 3'd7;
      set_in(op, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
      if (i % 8 == 0) rdata2_in = rdata1_in;
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rnd_stall[%0d]: got %b want 0", i, stall_out); end
      step();
      checks++; if (act !== model_out()) begin errors++; $display("FAIL rnd_alu[%0d] op %0d: got %h want %h", i, op, act, model_out()); end
    end
  endtask

  task automatic test_branch();
    set_in(3'b000, 16'h1234, 16'h1234, 16'hFFF8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0010);
    step();
    checks++; if ({branch_taken_out, branch_target_out} !== {1'b1, 16'h0008}) begin errors++; $display("FAIL beq_taken: got %b/%h want 1/0008", branch_taken_out, branch_target_out); end
    checks++; if (act !== model_out()) begin errors++; $display("FAIL beq_taken_all: got %h want %h", act, model_out()); end
    rdata2_in = 16'h1235;
    step();
    checks++; if (branch_taken_out !== 1'b0) begin errors++; $display("FAIL beq_not_taken: got %b want 0", branch_taken_out); end
    checks++; if (act !== model_out()) begin errors++; $display("FAIL beq_nt_all: got %h want %h", act, model_out()); end
  endtask

  task automatic test_mul(input logic [15:0] a, b, exp, input logic [3:0] wa, output int rcyc);
    int n = 0;
    set_in(3'b110, a, b, 16'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, wa, 16'($urandom));
    #1;
    while (stall_out === 1'b1 && n < 40) begin
      step();
      n++;
      checks++; if (act !== '0) begin errors++; $display("FAIL mul_bubble[%0d]: got %h want 0", n, act); end
    end
    checks++; if (n != 16) begin errors++; $display("FAIL mul_stall_len: got %0d want 16", n); end
    step();
    rcyc = cyc;
    checks++; if (alu_result_out !== exp) begin errors++; $display("FAIL mul_result: got %h want %h", alu_result_out, exp); end
    checks++; if (act !== model_out()) begin errors++; $display("FAIL mul_all: got %h want %h", act, model_out()); end
  endtask

  task automatic test_mul_directed();
    int c;
    logic [15:0] a, b;
    test_mul(16'h0123, 16'h0045, 16'h4E6F, 4'd1, c);
    test_mul(16'hFFFF, 16'hFFFF, 16'h0001, 4'd2, c);
    for (int i = 0; i < 3; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      test_mul(a, b, 16'(int'(a) * int'(b)), 4'($urandom), c);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    test_mul(16'd3, 16'd5, 16'h000F, 4'd3, c1);
    test_mul(16'd7, 16'd9, 16'h003F, 4'd4, c2);
    checks++; if (c2 - c1 != 17) begin errors++; $display("FAIL b2b_spacing: got %0d want 17", c2 - c1); end
    set_in(3'b000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 16'h0000);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL b2b_no_restart: got %b want 0", stall_out); end
    step();
    checks++; if (act !== model_out()) begin errors++; $display("FAIL b2b_after: got %h want %h", act, model_out()); end
  endtask

  task automatic test_reset_mid_mul();
    int c;
    set_in(3'b110, 16'd3, 16'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6, 16'h0020);
    repeat (5) step();
    rst = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL midrst_stall: got %b want 0", stall_out); end
    step();
    checks++; if (act !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", act); end
    rst = 1'b1;
    test_mul(16'h0123, 16'h0045, 16'h4E6F, 4'd6, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_branch();
    test_mul_directed();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
